// File: rtl/arbitro_wrr.sv
// rtl/arbitro_wrr.sv - weighted round-robin drain of four class FIFOs into four output FIFOs
// Mealy pop on grant, registered one-hot push one cycle later, credit reload per round.
module arbitro_wrr #(
  parameter int PESO_W = 3,
  parameter int DEST_W = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [3:0]            empty,
  input  logic [3:0]            almost_full,
  input  logic [4*DEST_W-1:0]   head_dest,
  input  logic [4*PESO_W-1:0]   pesos,
  output logic [3:0]            pop,
  output logic [3:0]            push,
  output logic                  idle,
  output logic                  ronda
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SERVE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PESO_W-1:0] credit_q [4];
  logic [PESO_W-1:0] credit_d [4];
  logic [1:0]        ptr_q, ptr_d;
  logic [3:0]        push_q, push_d;
  logic              ronda_q, ronda_d;

  logic [DEST_W-1:0] hd [4];
  logic [3:0]        elig;
  logic              round_end;
  logic              grant_vld;
  logic [1:0]        grant_idx;
  logic [1:0]        scan_idx;
  logic [3:0]        pop_c;

  // A class blocked only by backpressure still holds data and credit, so it keeps the round open.
  always_comb begin
    round_end = 1'b1;
    for (int i = 0; i < 4; i++) begin
      hd[i]   = head_dest[DEST_W*i +: DEST_W];
      elig[i] = !empty[i] && (credit_q[i] != '0) && !almost_full[hd[i]];
      if (!empty[i] && (credit_q[i] != '0)) begin
        round_end = 1'b0;
      end
    end
  end

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = ptr_q;
    scan_idx  = ptr_q;
    for (int k = 0; k < 4; k++) begin
      scan_idx = ptr_q + 2'(k);
      if (!grant_vld && elig[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    ptr_d    = ptr_q;
    push_d   = '0;
    ronda_d  = 1'b0;
    pop_c    = '0;
    case (state_q)
      IDLE: begin
        if (init) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        for (int i = 0; i < 4; i++) begin
          credit_d[i] = pesos[PESO_W*i +: PESO_W];
        end
        ronda_d = 1'b1;
        state_d = SERVE;
      end
      SERVE: begin
        if (!init) begin
          state_d = IDLE;
        end else if (round_end) begin
          for (int i = 0; i < 4; i++) begin
            credit_d[i] = pesos[PESO_W*i +: PESO_W];
          end
          ronda_d = 1'b1;
        end else if (grant_vld) begin
          pop_c               = 4'b0001 << grant_idx;
          credit_d[grant_idx] = credit_q[grant_idx] - PESO_W'(1);
          ptr_d               = (credit_q[grant_idx] == PESO_W'(1)) ? grant_idx + 2'd1 : grant_idx;
          push_d              = 4'b0001 << hd[grant_idx];
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      for (int i = 0; i < 4; i++) begin
        credit_q[i] <= '0;
      end
      ptr_q   <= '0;
      push_q  <= '0;
      ronda_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      ptr_q    <= ptr_d;
      push_q   <= push_d;
      ronda_q  <= ronda_d;
    end
  end

  // Reset masks the outputs immediately so a push pending across a reset never reaches fifo4..7.
  assign pop   = reset ? 4'b0000 : pop_c;
  assign push  = reset ? 4'b0000 : push_q;
  assign idle  = reset || (state_q == IDLE);
  assign ronda = ronda_q && !reset;

endmodule
